// File: rtl/datapath_controller_pkg.sv
// Shared encodings for the RISC datapath controller: FSM states, instruction
// classes, instruction field values and datapath select constants.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WIMM   = 3'd2,
        ST_GETA   = 3'd3,
        ST_GETB   = 3'd4,
        ST_ALU    = 3'd5,
        ST_WREG   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_MOVI = 3'd1,
        CLS_MOVR = 3'd2,
        CLS_ADD  = 3'd3,
        CLS_CMP  = 3'd4,
        CLS_AND  = 3'd5,
        CLS_MVN  = 3'd6,
        CLS_ILL  = 3'd7
    } class_e;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;

    localparam logic [1:0] OP_MOVI  = 2'b10;
    localparam logic [1:0] OP_MOVR  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CMP   = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_MVN   = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    function automatic class_e decode_class(input logic [2:0] opcode, input logic [1:0] op);
        class_e cls;
        cls = CLS_ILL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOVI)      cls = CLS_MOVI;
            else if (op == OP_MOVR) cls = CLS_MOVR;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction-side handshake and datapath control bundle of the controller.
interface datapath_controller_if;

    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic       illegal;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;

    // master: instruction source / datapath observer; slave: the controller
    modport master (
        output s, opcode, op,
        input  w, illegal, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
    );

    modport slave (
        input  s, opcode, op,
        output w, illegal, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
    );

endinterface

// File: rtl/datapath_controller_decode.sv
// Combinational classifier mapping the {opcode, op} instruction fields to a class.
module instr_class_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    output class_e     cls_o
);

    always_comb begin
        cls_o = decode_class(opcode_i, op_i);
    end

endmodule

// File: rtl/datapath_controller.sv
// Moore FSM sequencing the 16-bit RISC datapath, one instruction per start pulse.
module datapath_controller
    import datapath_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    datapath_controller_if.slave  bus
);

    state_e     state_q, state_d;
    class_e     cls_q, cls_d;
    class_e     dec_cls;
    logic       illegal_q, illegal_d;

    logic       w_c;
    logic [2:0] nsel_c;
    logic       loada_c, loadb_c, loadc_c, loads_c;
    logic       asel_c, bsel_c;
    logic [1:0] vsel_c;
    logic       write_c;

    instr_class_decode u_decode (
        .opcode_i (bus.opcode),
        .op_i     (bus.op),
        .cls_o    (dec_cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_WAIT;
            cls_q     <= CLS_NONE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = ST_WAIT;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        w_c       = 1'b0;
        nsel_c    = NSEL_NONE;
        loada_c   = 1'b0;
        loadb_c   = 1'b0;
        loadc_c   = 1'b0;
        loads_c   = 1'b0;
        asel_c    = 1'b0;
        bsel_c    = 1'b0;
        vsel_c    = VSEL_C;
        write_c   = 1'b0;

        case (state_q)
            ST_WAIT: begin
                w_c = 1'b1;
                if (bus.s) begin
                    state_d   = ST_DECODE;
                    cls_d     = dec_cls;
                    illegal_d = 1'b0;
                end
            end
            ST_DECODE: begin
                case (cls_q)
                    CLS_MOVI:                   state_d = ST_WIMM;
                    CLS_MOVR, CLS_MVN:          state_d = ST_GETB;
                    CLS_ADD, CLS_AND, CLS_CMP:  state_d = ST_GETA;
                    CLS_ILL: begin
                        state_d   = ST_WAIT;
                        illegal_d = 1'b1;
                    end
                    default:                    state_d = ST_WAIT;
                endcase
            end
            ST_WIMM: begin
                nsel_c  = NSEL_RN;
                vsel_c  = VSEL_IMM8;
                write_c = 1'b1;
                state_d = ST_WAIT;
            end
            ST_GETA: begin
                nsel_c  = NSEL_RN;
                loada_c = 1'b1;
                state_d = ST_GETB;
            end
            ST_GETB: begin
                nsel_c  = NSEL_RM;
                loadb_c = 1'b1;
                state_d = ST_ALU;
            end
            ST_ALU: begin
                // MOV Rd,Rm and MVN pass B alone through the ALU, so A is zeroed
                asel_c  = (cls_q == CLS_MOVR) || (cls_q == CLS_MVN);
                loadc_c = (cls_q != CLS_CMP);
                loads_c = (cls_q == CLS_CMP);
                state_d = (cls_q == CLS_CMP) ? ST_WAIT : ST_WREG;
            end
            ST_WREG: begin
                nsel_c  = NSEL_RD;
                vsel_c  = VSEL_C;
                write_c = 1'b1;
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign bus.w       = w_c;
    assign bus.illegal = illegal_q;
    assign bus.nsel    = nsel_c;
    assign bus.loada   = loada_c;
    assign bus.loadb   = loadb_c;
    assign bus.loadc   = loadc_c;
    assign bus.loads   = loads_c;
    assign bus.asel    = asel_c;
    assign bus.bsel    = bsel_c;
    assign bus.vsel    = vsel_c;
    assign bus.write   = write_c;

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Moore FSM that sequences the 16-bit RISC datapath for one instruction per start pulse.
- Drives the register-file field select (nsel), pipeline-register loads, operand muxes, writeback select and regfile write.
- Supported instructions: MOV Rn,#imm8; MOV Rd,Rm{sh}; ADD; CMP; AND; MVN.
- Sits between the instruction register/decoder and the datapath. ALUop and shift come straight from the instruction field and are not driven here.

Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- clk      in   1  rising-edge clock
- reset_n  in   1  asynchronous, active-low reset
- s        in   1  start; sampled only in WAIT
- opcode   in   3  instruction [15:13]
- op       in   2  instruction [12:11]
- w        out  1  1 = idle, ready for s
- illegal  out  1  sticky flag for an unsupported opcode/op; cleared on next accepted s
- nsel     out  3  one-hot regfile field select: 001 = Rn, 010 = Rd, 100 = Rm, 000 = none
- loada    out  1  load register A
- loadb    out  1  load register B
- loadc    out  1  load register C
- loads    out  1  load status register {N,V,Z}
- asel     out  1  1 = A operand forced to 0
- bsel     out  1  1 = B operand is sximm5, 0 = shifter output
- vsel     out  2  writeback select: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata
- write    out  1  regfile write enable

Behaviour:
- Clocking and reset:
  - One clock (clk); reset_n is asynchronous, active-low.
  - While reset_n = 0: state = WAIT, class register = NONE, illegal = 0.
- Outputs:
  - All outputs are combinational from state and the latched class. Outputs are glitch-free with respect to s/opcode/op because no raw input reaches them.
  - Defaults in every state: nsel = 000, vsel = 00, all loads/asel/bsel/write = 0.
  - w = 1 only in WAIT. Reset value: w = 1, all others 0.
- Acceptance:
  - In WAIT with s = 1, the rising edge latches the class decoded from {opcode,op} into an internal register, clears illegal, and moves to DECODE.
  - After acceptance, opcode/op may change without effect. s is ignored outside WAIT.
- Classes and state paths:
  - MOVI (110/10): DECODE → WIMM → WAIT
  - MOVR (110/00): DECODE → GETB → ALU → WREG → WAIT
  - ADD (101/00), AND (101/10): DECODE → GETA → GETB → ALU → WREG → WAIT
  - CMP (101/01): DECODE → GETA → GETB → ALU → WAIT
  - MVN (101/11): DECODE → GETB → ALU → WREG → WAIT
  - ILL (any other combination): DECODE → WAIT, with illegal set on the DECODE → WAIT edge
- State outputs:
  - WIMM: nsel = Rn, vsel = 10, write = 1
  - GETA: nsel = Rn, loada = 1
  - GETB: nsel = Rm, loadb = 1
  - ALU: asel = 1 for MOVR/MVN (else 0); bsel = 0; loadc = 1 except CMP; loads = 1 only for CMP
  - WREG: nsel = Rd, vsel = 00, write = 1
- Latency: w low for MOVI 2, MOVR 4, ADD/AND 5, CMP 4, MVN 4, ILL 1 cycles.
- Back-to-back: if s is held at 1 when WAIT is re-entered, the next instruction is accepted on the very next edge (w high for exactly one cycle).
- Reset mid-instruction: FSM returns to WAIT immediately. write/loads drop asynchronously, so no partial writeback occurs on a later edge.
- State register uses only the 7 legal encodings; any unreachable encoding transitions to WAIT on the next edge.

Decomposition:
- Package datapath_ctrl_pkg holds:
  - state encodings (3-bit: WAIT, DECODE, WIMM, GETA, GETB, ALU, WREG)
  - class encodings (NONE, MOVI, MOVR, ADD, CMP, AND, MVN, ILL)
  - opcode/op constants
  - nsel one-hot constants (NSEL_RN, NSEL_RD, NSEL_RM)
  - vsel constants (VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA)
- One sub-module: instr_class_decode, combinational {opcode,op} → class, instantiated once in front of the class register.

Test Plan:
- Reset, then MOVI (s = 1 for one cycle, opcode = 110, op = 10) → w = 0 for 2 cycles; the WIMM cycle shows nsel = 001, vsel = 10, write = 1; w = 1 afterwards, illegal = 0.
- ADD (101/00) → per-cycle sequence checked exactly: DECODE all 0; loada + nsel 001; loadb + nsel 100; loadc with asel = bsel = 0; write + nsel 010 + vsel 00. w low for 5 cycles.
- CMP (101/01) → the ALU cycle has loads = 1, loadc = 0; write never asserted; w low for 4 cycles.
- MVN then MOVR with s held high → asel = 1 in each ALU cycle; w high for exactly 1 cycle between the two instructions; opcode changed mid-instruction has no effect.
- Illegal opcode 011/00 → w low 1 cycle; illegal = 1 on return to WAIT; no load or write asserted; next accepted s clears illegal.
- reset_n pulsed low during the GETB cycle of ADD → loadb falls immediately; after release the FSM is in WAIT with w = 1, and no write occurs within 10 subsequent cycles without s.
